// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the instruction-fetch stage:
//   - default reset PC and pipeline bubble encoding
//   - fetch FSM state encoding
//   - fetch-queue entry {inst, pc4}
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned QCNT_W = 2;             // queue holds 0..2 entries
    localparam int unsigned LVL_W  = QCNT_W + 1;    // headroom for occupancy sums

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [XLEN-1:0] BUBBLE_INST_DEFAULT = 32'h0400_0000;
    localparam logic [XLEN-1:0] PC_STEP             = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,     // no request outstanding
        ST_REQ  = 2'd1,     // request outstanding, response wanted
        ST_DROP = 2'd2      // request outstanding, response is stale
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory req/ack port.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned fetch address, stable while imem_req is high
//   imem_ack   : response valid (may coincide with imem_req)
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);

    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Two-entry FIFO of fetched {inst, pc4} records.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data at tail
//   i_pop    : drop head entry
//   i_clear  : empty the queue (wins over push/pop)
//   i_data   : entry to push
//   o_head   : head entry (meaningful only when o_count != 0)
//   o_count  : number of valid entries
// ---------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  fetch_entry_t      i_data,
    output fetch_entry_t      o_head,
    output logic [QCNT_W-1:0] o_count
);

    fetch_entry_t      r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [QCNT_W-1:0] r_count;

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + QCNT_W'(i_push) - QCNT_W'(i_pop);
        end
    end

    // Storage needs no reset: it is only observed through a valid count.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// MIPS IF stage: owns the PC, fetches over a variable-latency req/ack port,
// buffers up to two instructions and presents the head to IF/ID.
//   clk, rst    : clock, asynchronous active-high reset
//   imem        : instruction-memory port (master side)
//   stall_i     : hazard stall, head is held
//   redirect_i  : taken branch/jump, flushes queue and retargets the PC
//   redirect_pc : redirect target (low two bits ignored)
//   if_pc       : PC+4 of head instruction, 0 when empty
//   if_inst     : head instruction, BUBBLE_INST when empty
//   if_valid    : queue non-empty
//   if_flush    : IF/ID flush, mirrors redirect_i
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
)(
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  imem,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_inst,
    output logic             if_valid,
    output logic             if_flush
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_req_addr;
    logic [XLEN-1:0]   w_req_addr_nxt;
    logic [XLEN-1:0]   w_pc_plus4;
    logic              w_req;
    logic [XLEN-1:0]   w_addr;
    logic              w_push;
    logic              w_consume;
    logic              w_valid;
    logic [LVL_W-1:0]  w_level;
    logic [QCNT_W-1:0] w_count;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    assign w_valid    = (w_count != '0);
    assign w_consume  = w_valid && !stall_i && !redirect_i;
    assign w_pc_plus4 = r_pc + PC_STEP;
    // Occupancy after this cycle's pop; a new fetch only issues if it has a slot.
    assign w_level    = LVL_W'(w_count) - LVL_W'(w_consume);

    // State, PC and in-flight address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    // Fetch FSM: request issue, ack handling and redirect.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_addr_nxt   = r_req_addr;
        w_req            = 1'b0;
        w_addr           = r_req_addr;
        w_push           = 1'b0;
        w_push_data.inst = imem.imem_rdata;
        w_push_data.pc4  = w_pc_plus4;

        unique case (r_state)
            ST_RUN: begin
                // Held low during reset so the memory sees no request.
                if (!rst && (w_level < LVL_W'(2))) begin
                    w_req          = 1'b1;
                    w_addr         = r_pc;
                    w_req_addr_nxt = r_pc;
                    if (imem.imem_ack) begin
                        if (!redirect_i) begin
                            w_push   = 1'b1;
                            w_pc_nxt = w_pc_plus4;
                        end
                    end else begin
                        w_state_nxt = redirect_i ? ST_DROP : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (imem.imem_ack) begin
                    if (!redirect_i) begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_pc_plus4;
                    end
                    w_state_nxt = ST_RUN;
                end else if (redirect_i) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // Keep the old request alive until it completes, then discard it.
                w_req = 1'b1;
                if (imem.imem_ack) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (redirect_i) begin
            w_pc_nxt = word_align(redirect_pc);
        end
    end

    if_fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_consume),
        .i_clear (redirect_i),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;

    assign if_valid = w_valid;
    assign if_inst  = w_valid ? w_head.inst : BUBBLE_INST;
    assign if_pc    = w_valid ? w_head.pc4  : '0;
    assign if_flush = redirect_i;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit with a latency-programmable memory model.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] BUB = 32'h0400_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_flush;

    int   lat;
    int   wcnt;
    logic ack_force;
    int   n_checks;
    int   n_errors;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .BUBBLE_INST (32'h0400_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .stall_i     (stall),
        .redirect_i  (redir),
        .redirect_pc (rpc),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .if_flush    (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    // Memory model: ack after 'lat' wait cycles (0 = same cycle as req).
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (imem_bus.imem_req && !imem_bus.imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always_comb begin
        imem_bus.imem_ack   = ack_force || (imem_bus.imem_req && (wcnt >= lat));
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_valid,
                           input logic [31:0] e_pc, input logic [31:0] e_inst);
        chk1 ({tag, ".valid"}, if_valid, e_valid);
        chk32({tag, ".pc"},    if_pc,    e_pc);
        chk32({tag, ".inst"},  if_inst,  e_inst);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_flush;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] p,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei, input logic ef);
        vec_t v;
        v.stall = s;  v.redir = r;  v.rpc = p;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_pc = ep;  v.e_inst = ei; v.e_flush = ef;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        lat       = 0;
        ack_force = 1'b0;
        stall     = 1'b0;
        redir     = 1'b0;
        rpc       = 32'h0;
        rst       = 1'b1;

        // Zero-wait streaming, stall, redirects (with stall, with ack) and PC wrap.
        vecs.push_back(mk(0,0,32'h0,          1,32'h0,         0,32'h0,   BUB,                   0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h4,         1,32'h4,   mem_word(32'h0),       0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h8,         1,32'h8,   mem_word(32'h4),       0));
        vecs.push_back(mk(1,0,32'h0,          1,32'hC,         1,32'hC,   mem_word(32'h8),       0));
        vecs.push_back(mk(1,0,32'h0,          0,32'h0,         1,32'hC,   mem_word(32'h8),       0));
        vecs.push_back(mk(1,0,32'h0,          0,32'h0,         1,32'hC,   mem_word(32'h8),       0));
        vecs.push_back(mk(1,0,32'h0,          0,32'h0,         1,32'hC,   mem_word(32'h8),       0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h10,        1,32'hC,   mem_word(32'h8),       0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h14,        1,32'h10,  mem_word(32'hC),       0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h18,        1,32'h14,  mem_word(32'h10),      0));
        vecs.push_back(mk(1,1,32'h203,        0,32'h0,         1,32'h18,  mem_word(32'h14),      1));
        vecs.push_back(mk(0,0,32'h0,          1,32'h200,       0,32'h0,   BUB,                   0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h204,       1,32'h204, mem_word(32'h200),     0));
        vecs.push_back(mk(0,1,32'h40,         1,32'h208,       1,32'h208, mem_word(32'h204),     1));
        vecs.push_back(mk(0,0,32'h0,          1,32'h40,        0,32'h0,   BUB,                   0));
        vecs.push_back(mk(1,0,32'h0,          1,32'h44,        1,32'h44,  mem_word(32'h40),      0));
        vecs.push_back(mk(1,0,32'h0,          0,32'h0,         1,32'h44,  mem_word(32'h40),      0));
        vecs.push_back(mk(0,1,32'hFFFF_FFFD,  0,32'h0,         1,32'h44,  mem_word(32'h40),      1));
        vecs.push_back(mk(0,0,32'h0,          1,32'hFFFF_FFFC, 0,32'h0,   BUB,                   0));
        vecs.push_back(mk(0,0,32'h0,          1,32'h0,         1,32'h0,   mem_word(32'hFFFF_FFFC),0));
        vecs.push_back(mk(1,0,32'h0,          1,32'h4,         1,32'h4,   mem_word(32'h0),       0));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst.req", imem_bus.imem_req, 1'b0);
        chk_out("rst", 1'b0, 32'h0, BUB);
        chk1("rst.flush", if_flush, 1'b0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (vecs[i]) begin
            stall = vecs[i].stall;
            redir = vecs[i].redir;
            rpc   = vecs[i].rpc;
            @(negedge clk);
            chk1($sformatf("v%0d.req", i), imem_bus.imem_req, vecs[i].e_req);
            if (vecs[i].e_req)
                chk32($sformatf("v%0d.addr", i), imem_bus.imem_addr, vecs[i].e_addr);
            chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
            chk1($sformatf("v%0d.flush", i), if_flush, vecs[i].e_flush);
            next_cycle();
        end
        stall = 1'b0;
        redir = 1'b0;

        // 3-cycle memory, redirect during the 2nd wait cycle.
        lat   = 3;
        redir = 1'b1;
        rpc   = 32'h80;
        @(negedge clk);
        chk1("lat.a.req", imem_bus.imem_req, 1'b0);
        next_cycle();
        redir = 1'b0;
        @(negedge clk);
        chk1 ("lat.b.req",  imem_bus.imem_req,  1'b1);
        chk32("lat.b.addr", imem_bus.imem_addr, 32'h80);
        next_cycle();
        @(negedge clk);
        chk1("lat.c.ack", imem_bus.imem_ack, 1'b0);
        next_cycle();
        redir = 1'b1;
        rpc   = 32'h100;
        @(negedge clk);
        chk1 ("lat.d.flush", if_flush,           1'b1);
        chk1 ("lat.d.req",   imem_bus.imem_req,  1'b1);
        chk32("lat.d.addr",  imem_bus.imem_addr, 32'h80);
        next_cycle();
        redir = 1'b0;
        @(negedge clk);
        chk1 ("lat.e.flush", if_flush,           1'b0);
        chk1 ("lat.e.ack",   imem_bus.imem_ack,  1'b1);
        chk32("lat.e.addr",  imem_bus.imem_addr, 32'h80);
        chk1 ("lat.e.valid", if_valid,           1'b0);
        next_cycle();
        @(negedge clk);
        chk1 ("lat.f.valid", if_valid,           1'b0);
        chk32("lat.f.addr",  imem_bus.imem_addr, 32'h100);
        begin
            int waited;
            waited = 0;
            while (!if_valid && waited < 10) begin
                next_cycle();
                @(negedge clk);
                waited++;
            end
            chk1("lat.first_valid_in_time", if_valid, 1'b1);
            chk_out("lat.first", 1'b1, 32'h104, mem_word(32'h100));
        end

        // Reset while a request is outstanding; a late ack is ignored.
        next_cycle();
        @(negedge clk);
        chk1 ("mid.req",  imem_bus.imem_req,  1'b1);
        chk32("mid.addr", imem_bus.imem_addr, 32'h104);
        #1;
        rst       = 1'b1;
        ack_force = 1'b1;
        #1;
        chk1("mid.rst.req", imem_bus.imem_req, 1'b0);
        chk_out("mid.rst", 1'b0, 32'h0, BUB);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        ack_force = 1'b0;
        lat       = 0;
        stall     = 1'b1;
        @(negedge clk);
        chk1 ("rs.0.req",  imem_bus.imem_req,  1'b1);
        chk32("rs.0.addr", imem_bus.imem_addr, 32'h0);
        chk_out("rs.0", 1'b0, 32'h0, BUB);
        next_cycle();
        @(negedge clk);
        chk32("rs.1.addr", imem_bus.imem_addr, 32'h4);
        chk_out("rs.1", 1'b1, 32'h4, mem_word(32'h0));
        next_cycle();
        // Queue full: no request, and an unsolicited ack must not be taken.
        ack_force = 1'b1;
        @(negedge clk);
        chk1("rs.2.req", imem_bus.imem_req, 1'b0);
        chk_out("rs.2", 1'b1, 32'h4, mem_word(32'h0));
        next_cycle();
        ack_force = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        chk32("rs.3.addr", imem_bus.imem_addr, 32'h8);
        chk_out("rs.3", 1'b1, 32'h4, mem_word(32'h0));
        next_cycle();
        @(negedge clk);
        chk_out("rs.4", 1'b1, 32'h8, mem_word(32'h4));
        next_cycle();
        @(negedge clk);
        chk_out("rs.5", 1'b1, 32'hC, mem_word(32'h8));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory req/ack port.
- Buffers up to 2 fetched instructions.
- Presents the head instruction with its PC+4 to IF/ID, honouring hazard stalls and branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUBBLE_INST, 32'h0400_0000, team bubble encoding driven when no valid instruction (same as IF/ID reset/flush value)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  response valid; may arrive in the same cycle as req (zero-wait) or later
imem_rdata  in  32  instruction, valid with imem_ack
stall_i  in  1  hazard unit stall (= !IF_IDWrite); head is not consumed
redirect_i  in  1  taken branch/jump from ID
redirect_pc  in  32  target address
if_pc  out  32  PC+4 of head instruction; 0 when empty
if_inst  out  32  head instruction; BUBBLE_INST when empty
if_valid  out  1  queue non-empty
if_flush  out  1  flush to IF/ID; equals redirect_i (combinational)

Behaviour:
- Reset is asynchronous. It sets:
  - pc=RESET_PC, queue empty, state RUN, imem_req=0
  - if_inst=BUBBLE_INST, if_pc=0, if_valid=0
- Queue: 2 entries of {inst, pc4}, head drives outputs.
  - consume = if_valid & !stall_i & !redirect_i.
  - pop on consume.
- States:
  - RUN: no request outstanding.
  - REQ: request outstanding.
  - DROP: outstanding request is stale.
- Issue rule in RUN and REQ: imem_req=1 and imem_addr=pc when (count - consume + outstanding) < 2.
  - Once req is high it stays high, with imem_addr stable, until ack.
  - This guarantees an ack always has a free slot.
- Ack in RUN/REQ (not redirected): push {imem_rdata, pc+4}; pc <= pc+4.
  - Push and pop in the same cycle keep count unchanged.
  - With zero-wait memory and no stall, throughput is 1 instruction/cycle; the fetch-to-if_valid latency is 1 cycle.
- Ack absent while req is high: state REQ.
- Redirect (priority over stall and ack):
  - Queue cleared and pc <= redirect_pc.
  - if_flush=1 in that cycle only.
  - If a request is outstanding and no ack arrives this cycle: go to DROP. Keep req/addr on the old address until ack, discard that data, then go to RUN and fetch redirect_pc.
  - If ack arrives in the redirect cycle: discard the data, state RUN.
  - A redirect in DROP updates pc and stays in DROP.
- Stall: head and if_pc/if_inst are held stable. Fetch continues until the queue is full, then imem_req=0 (unless a request is still outstanding).
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is ignored and forced to 00.
- Reset mid-request: state returns to RUN and any later ack is ignored until a new req is issued. The memory must drop its request on reset.

Decomposition:
- Shared package holds RESET_PC, BUBBLE_INST, the state encoding (RUN/REQ/DROP) and the queue-entry struct {inst, pc4}.
- Natural sub-module: if_fetch_queue, a 2-entry FIFO with push/pop/clear, count and head outputs.
- FSM and PC live in the top module.

Test Plan:
- Reset then release, zero-wait memory, no stall → imem_addr 0,4,8,…; if_inst follows the memory contents 1 cycle later; if_pc 4,8,12; if_valid=1 from the 2nd cycle.
- Stall for 4 cycles during streaming → outputs frozen on the same instruction; at most 2 further acks accepted; imem_req=0 once full; after release the queue drains in order with no loss or duplication.
- 3-cycle memory latency, redirect_pc=0x100 in the 2nd wait cycle → if_flush pulses 1 cycle; the stale ack for the old address is discarded; next imem_addr=0x100; first valid if_pc=0x104.
- Redirect to 0x40 in the same cycle as an ack → that data is not pushed; queue empty; next request to 0x40.
- Redirect and stall asserted together with queue full → redirect wins; if_valid=0 and if_inst=0x0400_0000 the next cycle.
- Assert rst mid-outstanding-request, then release → all outputs at reset values; fetch restarts at RESET_PC; the memory's old ack does not enter the queue.
